rr_mux_sel_arbiter: RTL

// - Round-robin arbiter that sits directly upstream of the 4-to-1 mux tree.
// - Owns the mux's 2-bit select: takes 4 request lines, grants one source at a time,
//   and drives sel[1:0] together with a one-hot grant.
// - Holds each grant until the source signals done, withdraws its request, or a hold timeout expires.

---
 rtl/rr_mux_sel_arbiter_pkg.sv | 18 +
 rtl/rr_mux_sel_arbiter_pick4.sv | 36 +++
 rtl/rr_mux_sel_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter.
package rr_mux_sel_arbiter_pkg;

    // Two-state arbitration FSM
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SEL_W   = 2;

    // Convert a source index into its one-hot grant vector
    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux_sel_arbiter_pick4.sv
// Combinational round-robin pick: first set request at or after ptr (mod 4).
module rr_pick4
    import rr_mux_sel_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [SEL_W-1:0]     enc;
    logic                 found;

    // Rotate right by ptr so the highest-priority source lands at bit 0
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_SRC-1:0];

    // Fixed-priority encode of the rotated vector (lowest bit wins)
    always_comb begin
        enc   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found && rot[i]) begin
                enc   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

    // Undo the rotation; the 2-bit add wraps mod 4
    assign idx = enc + ptr;
    assign any = |req;

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter owning the 4-to-1 mux select; grants are held until
// done, request withdrawal, or hold timeout, with one idle bubble between grants.
module rr_mux_sel_arbiter
    import rr_mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy
);

    localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = TIMEOUT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t             state, state_next;
    logic [SEL_W-1:0]   ptr, ptr_next;
    logic [SEL_W-1:0]   sel_next;
    logic [NUM_SRC-1:0] grant_next;
    logic               busy_next;
    logic [CNT_W-1:0]   hold_cnt, cnt_next;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               rel;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Release the current grant on done, dropped request, or last permitted cycle
    assign rel = done | ~req[sel] | (TIMEOUT_EN && (hold_cnt == HOLD_LAST));

    // State, pointer, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            sel      <= sel_next;
            grant    <= grant_next;
            busy     <= busy_next;
            hold_cnt <= cnt_next;
        end
    end

    // Next-state and next-output logic; sel only moves on IDLE->GRANT
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        sel_next   = sel;
        grant_next = grant;
        busy_next  = busy;
        cnt_next   = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_next   = pick_idx;
                    grant_next = onehot(pick_idx);
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    grant_next = '0;
                    busy_next  = 1'b0;
                    ptr_next   = sel + SEL_W'(1);
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = hold_cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
